// File: rtl/count_dec_pkg.sv
// count_dec_pkg: shared state/class enums and step constants for count_step_decoder
package count_dec_pkg;
    typedef enum logic [1:0] {SYNC, TRACK, FAULT} state_t;
    typedef enum logic [1:0] {CLS_UP, CLS_DOWN, CLS_HOLD, CLS_JUMP} cls_t;
    localparam int DELTA_UP = 1;
    localparam int DELTA_DOWN = -1;
endpackage

// File: rtl/count_delta_classify.sv
// count_delta_classify: classifies count_i - prev_i (mod 2^WIDTH) and flags wrap
module count_delta_classify
    import count_dec_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] prev_i,
    input  logic [WIDTH-1:0] count_i,
    output cls_t             cls_o,
    output logic             wrap_o
);
    logic [WIDTH-1:0] delta;
    always_comb begin
        delta = count_i - prev_i;
        cls_o = (delta == WIDTH'(DELTA_UP))   ? CLS_UP :
                (delta == WIDTH'(DELTA_DOWN)) ? CLS_DOWN :
                (delta == '0)                 ? CLS_HOLD : CLS_JUMP;
        wrap_o = (cls_o == CLS_UP && &prev_i) || (cls_o == CLS_DOWN && prev_i == '0);
    end
endmodule

// File: rtl/count_step_decoder.sv
// count_step_decoder: decodes observed counter changes into step/hold/jump pulses with run length and sticky fault
// Defining COUNT_DEC_STATS_EN adds err_total, a saturating jump_err count cleared only by rst.
module count_step_decoder
    import count_dec_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int RUN_W       = 8,
    parameter int FAULT_LIMIT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] count_in,
    input  logic             sample,
    input  logic             resync,
    output logic             step_up,
    output logic             step_down,
    output logic             hold,
    output logic             wrap,
    output logic             jump_err,
    output logic             dir_out,
    output logic [RUN_W-1:0] run_len,
    output logic             fault
`ifdef COUNT_DEC_STATS_EN
    ,
    output logic [7:0]       err_total
`endif
);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [RUN_W-1:0] run_q, run_d, run_sat;
    logic [3:0]       jcnt_q, jcnt_d, jcnt_inc;
    logic             dir_q, dir_d, fault_q, fault_d;
    logic             up_q, up_d, dn_q, dn_d, hold_q, hold_d, wrap_q, wrap_d, jump_q, jump_d;
    cls_t             cls;
    logic             wrap_c;

    count_delta_classify #(.WIDTH(WIDTH)) u_cls (
        .prev_i  (prev_q),
        .count_i (count_in),
        .cls_o   (cls),
        .wrap_o  (wrap_c)
    );

    assign run_sat  = &run_q ? run_q : run_q + RUN_W'(1);
    assign jcnt_inc = jcnt_q + 4'd1;

    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        run_d   = run_q;
        jcnt_d  = jcnt_q;
        dir_d   = dir_q;
        fault_d = fault_q;
        up_d    = 1'b0;
        dn_d    = 1'b0;
        hold_d  = 1'b0;
        wrap_d  = 1'b0;
        jump_d  = 1'b0;
        if (resync) begin
            state_d = SYNC;
            fault_d = 1'b0;
            jcnt_d  = '0;
            run_d   = '0;
        end else if (sample) begin
            case (state_q)
                SYNC: begin
                    prev_d  = count_in;
                    run_d   = '0;
                    state_d = TRACK;
                end
                TRACK: begin
                    prev_d  = count_in;
                    up_d    = cls == CLS_UP;
                    dn_d    = cls == CLS_DOWN;
                    hold_d  = cls == CLS_HOLD;
                    jump_d  = cls == CLS_JUMP;
                    wrap_d  = wrap_c;
                    jcnt_d  = jump_d ? jcnt_inc : '0;
                    if (up_d || dn_d) begin
                        dir_d = up_d;
                        run_d = (up_d == dir_q) ? run_sat : RUN_W'(1);
                    end
                    if (jump_d) run_d = '0;
                    fault_d = jump_d && jcnt_inc == 4'(FAULT_LIMIT);
                    state_d = fault_d ? FAULT : TRACK;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SYNC;
            prev_q  <= '0;
            run_q   <= '0;
            jcnt_q  <= '0;
            dir_q   <= 1'b1;
            fault_q <= 1'b0;
            up_q    <= 1'b0;
            dn_q    <= 1'b0;
            hold_q  <= 1'b0;
            wrap_q  <= 1'b0;
            jump_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            run_q   <= run_d;
            jcnt_q  <= jcnt_d;
            dir_q   <= dir_d;
            fault_q <= fault_d;
            up_q    <= up_d;
            dn_q    <= dn_d;
            hold_q  <= hold_d;
            wrap_q  <= wrap_d;
            jump_q  <= jump_d;
        end
    end

`ifdef COUNT_DEC_STATS_EN
    logic [7:0] err_q;
    always_ff @(posedge clk) begin
        if (rst) err_q <= '0;
        else if (jump_d && ~&err_q) err_q <= err_q + 8'd1;
    end
    assign err_total = err_q;
`endif

    assign step_up   = up_q;
    assign step_down = dn_q;
    assign hold      = hold_q;
    assign wrap      = wrap_q;
    assign jump_err  = jump_q;
    assign dir_out   = dir_q;
    assign run_len   = run_q;
    assign fault     = fault_q;
endmodule

// File: tb/tb_count_step_decoder.sv
// tb_count_step_decoder: table-driven scoreboard bench for count_step_decoder
module tb_count_step_decoder;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sample = 1'b0;
    logic       resync = 1'b0;
    logic [7:0] count_in = 8'h00;
    logic       step_up, step_down, hold, wrap, jump_err, dir_out, fault;
    logic [7:0] run_len;
`ifdef COUNT_DEC_STATS_EN
    logic [7:0] err_total;
`endif

    int errors = 0;
    int checks = 0;

    localparam logic [4:0] P0 = 5'b00000, UP = 5'b10000, DN = 5'b01000,
                           HD = 5'b00100, WR = 5'b00010, JP = 5'b00001;

    typedef struct {
        logic       rst, smp, rsy;
        logic [7:0] cnt;
        logic [4:0] pul;
        logic       dir;
        logic [7:0] run;
        logic       flt;
    } vec_t;

    vec_t tab[$];
    vec_t sb[$];

    count_step_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .count_in  (count_in),
        .sample    (sample),
        .resync    (resync),
        .step_up   (step_up),
        .step_down (step_down),
        .hold      (hold),
        .wrap      (wrap),
        .jump_err  (jump_err),
        .dir_out   (dir_out),
        .run_len   (run_len),
        .fault     (fault)
`ifdef COUNT_DEC_STATS_EN
        ,
        .err_total (err_total)
`endif
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic s, input logic y, input logic [7:0] c,
                       input logic [4:0] p, input logic d, input logic [7:0] n, input logic f);
        vec_t v;
        v.rst = r; v.smp = s; v.rsy = y; v.cnt = c;
        v.pul = p; v.dir = d; v.run = n; v.flt = f;
        tab.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d: got %0h want %0h", nm, idx, act, exp);
        end
    endtask

    task automatic apply(input int idx);
        vec_t e;
        rst = tab[idx].rst;
        sample = tab[idx].smp;
        resync = tab[idx].rsy;
        count_in = tab[idx].cnt;
        sb.push_back(tab[idx]);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("pulses", idx, {3'b000, step_up, step_down, hold, wrap, jump_err}, {3'b000, e.pul});
        chk("dir_out", idx, {7'd0, dir_out}, {7'd0, e.dir});
        chk("run_len", idx, run_len, e.run);
        chk("fault", idx, {7'd0, fault}, {7'd0, e.flt});
    endtask

    initial begin
        int mark;
        // reset, then basic up counting, sample low holds
        add(1,0,0,8'h00, P0,1,0,0);
        add(1,1,0,8'h33, P0,1,0,0);
        add(0,1,0,8'h05, P0,1,0,0);
        add(0,1,0,8'h06, UP,1,1,0);
        add(0,1,0,8'h07, UP,1,2,0);
        add(0,0,0,8'h99, P0,1,2,0);
        // up-wrap through all-ones
        add(0,0,1,8'h00, P0,1,0,0);
        add(0,1,0,8'hFE, P0,1,0,0);
        add(0,1,0,8'hFF, UP,1,1,0);
        add(0,1,0,8'h00, UP|WR,1,2,0);
        // direction flips, hold, jump then hold
        add(0,0,1,8'h00, P0,1,0,0);
        add(0,1,0,8'h10, P0,1,0,0);
        add(0,1,0,8'h0F, DN,0,1,0);
        add(0,1,0,8'h10, UP,1,1,0);
        add(0,1,0,8'h10, HD,1,1,0);
        add(0,1,0,8'h20, JP,1,0,0);
        add(0,1,0,8'h20, HD,1,0,0);
        // three jumps force fault; samples ignored; resync reloads
        add(0,1,0,8'h00, JP,1,0,0);
        add(0,1,0,8'h40, JP,1,0,0);
        add(0,1,0,8'h80, JP,1,0,1);
        add(0,1,0,8'hC0, P0,1,0,1);
        add(0,1,0,8'h81, P0,1,0,1);
        add(0,0,0,8'h00, P0,1,0,1);
        add(0,0,1,8'h00, P0,1,0,0);
        add(0,1,0,8'h50, P0,1,0,0);
        add(0,1,0,8'h51, UP,1,1,0);
        // a step between jumps clears the consecutive count
        add(0,1,0,8'h70, JP,1,0,0);
        add(0,1,0,8'h90, JP,1,0,0);
        add(0,1,0,8'h91, UP,1,1,0);
        add(0,1,0,8'hB0, JP,1,0,0);
        add(0,1,0,8'hD0, JP,1,0,0);
        add(0,1,0,8'hD1, UP,1,1,0);
        // resync wins over simultaneous sample
        add(0,1,1,8'hE0, P0,1,0,0);
        add(0,1,0,8'hE1, P0,1,0,0);
        add(0,1,0,8'hE2, UP,1,1,0);
        add(0,1,0,8'hE1, DN,0,1,0);
        // down-wrap from zero
        add(0,0,1,8'h00, P0,0,0,0);
        add(0,1,0,8'h00, P0,0,0,0);
        add(0,1,0,8'hFF, DN|WR,0,1,0);
        add(0,1,0,8'hFE, DN,0,2,0);
        // run_len saturation over a long up run
        add(0,0,1,8'h00, P0,0,0,0);
        add(0,1,0,8'h00, P0,0,0,0);
        for (int i = 1; i <= 260; i++)
            add(0,1,0,8'(i), (i % 256 == 0) ? (UP|WR) : UP, 1, (i > 255) ? 8'hFF : 8'(i), 0);
        // fault then reset overrides it
        add(0,1,0,8'h40, JP,1,0,0);
        add(0,1,0,8'h80, JP,1,0,0);
        add(0,1,0,8'hC0, JP,1,0,1);
        mark = tab.size();
        add(1,1,0,8'h55, P0,1,0,0);
        add(0,1,0,8'h10, P0,1,0,0);
        add(0,1,0,8'h0F, DN,0,1,0);

        for (int i = 0; i < mark; i++) apply(i);
`ifdef COUNT_DEC_STATS_EN
        chk("err_total_pre_rst", mark, err_total, 8'd11);
`endif
        for (int i = mark; i < tab.size(); i++) apply(i);
`ifdef COUNT_DEC_STATS_EN
        chk("err_total_post_rst", tab.size(), err_total, 8'd0);
`endif
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: %0d entries left, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
